// File: rtl/cordic_seq.sv
// Iterative 16-step CORDIC rotator: one angle in, cos/sin out, sequencing the
// external arctangent constant ROM one address per cycle.
module cordic_seq #(
   parameter logic [19:0] X_INIT = 20'h04DBA
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [19:0] angle,
   output logic [3:0]  rom_addr,
   input  logic [19:0] rom_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [19:0] cos_out,
   output logic [19:0] sin_out,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; ready/valid outputs come only from registered state, never
   // combinationally from the partner's valid/ready.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic signed [19:0] r_x;
   logic signed [19:0] r_y;
   logic signed [19:0] r_z;
   logic [3:0]         r_iter;
   logic signed [19:0] w_x_sh;
   logic signed [19:0] w_y_sh;

   assign w_x_sh = r_x >>> r_iter;
   assign w_y_sh = r_y >>> r_iter;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      rom_addr    = 4'd0;
      unique case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            busy     = 1'b1;
            rom_addr = r_iter;
            if (r_iter == 4'd15) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Rotation direction follows the sign of the residual angle z.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x    <= '0;
         r_y    <= '0;
         r_z    <= '0;
         r_iter <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_x    <= X_INIT;
                  r_y    <= '0;
                  r_z    <= $signed(angle);
                  r_iter <= '0;
               end
            end
            S_RUN: begin
               if (!r_z[19]) begin
                  r_x <= r_x - w_y_sh;
                  r_y <= r_y + w_x_sh;
                  r_z <= r_z - $signed(rom_data);
               end else begin
                  r_x <= r_x + w_y_sh;
                  r_y <= r_y - w_x_sh;
                  r_z <= r_z + $signed(rom_data);
               end
               r_iter <= r_iter + 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign cos_out   = r_x;
   assign sin_out   = r_y;
   assign dbg_state = r_state;

endmodule

// File: doc/cordic_seq.md
# cordic_seq

Iterative CORDIC rotation engine for the DDS phase-to-amplitude path. Takes one phase angle per transaction and sequences 16 micro-rotations, stepping the 4-bit address of the arctangent constant ROM (`cordicconst`) once per cycle. It returns cos/sin through a valid/ready handshake. It sits between the phase accumulator and the DAC output register and is the sole master of the constant ROM.

## Interface

- `X_INIT`, 20'h04DBA: initial x register value. This is the CORDIC gain compensation K·2^15 for 16 iterations.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: an angle is presented on `angle`.
- `in_ready`  out  1: the block accepts an angle this cycle.
- `angle`  in  20: signed two's-complement angle, Q.15 radians (2^15 = 1 rad). Legal range is ±20'h0C90F (±π/2).
- `rom_addr`  out  4: address to the constant ROM, which equals the current iteration index.
- `rom_data`  in  20: atan(2^-i)·2^15 returned combinationally by the ROM for `rom_addr`.
- `out_valid`  out  1: `cos_out` and `sin_out` hold a result.
- `out_ready`  in  1: the consumer takes the result.
- `cos_out`  out  20: signed Q.15 cosine, equal to the x register.
- `sin_out`  out  20: signed Q.15 sine, equal to the y register.
- `busy`  out  1: high in the RUN and DONE states.

## Operation

- The FSM has three states: IDLE, RUN and DONE. On reset it enters IDLE. The x, y and z registers and the 4-bit `iter` counter all reset to 0.
- Reset values of the outputs:
  - `in_ready`=1 and `out_valid`=0.
  - `cos_out`=0 and `sin_out`=0.
  - `rom_addr`=0 and `busy`=0.
- **IDLE:** `in_ready`=1. When `in_valid` is high at a rising edge:
  - x←`X_INIT`, y←0, z←`angle`, `iter`←0.
  - The FSM moves to RUN.
- **RUN:** `in_ready`=0 and `rom_addr`=`iter`. Let d=+1 if z[19]=0, otherwise d=−1. At each edge:
  - x←x − d·(y>>>iter)
  - y←y + d·(x>>>iter), using the pre-update x.
  - z←z − d·`rom_data`
  - `iter`←`iter`+1.
- **RUN exit:** the edge that processes `iter`=15 moves the FSM to DONE, and `iter` wraps to 0.
- **DONE:** `out_valid`=1 and the x/y registers are frozen. When `out_ready` is high at an edge, the FSM returns to IDLE.
- **Arithmetic:**
  - All registers are 20-bit signed. Shifts are arithmetic, with truncation toward −∞.
  - Add and subtract wrap modulo 2^20; no saturation.
  - Inside the legal range, |x| and |y| stay at or below 2^15+64, so no wrap occurs.
- **Out-of-range angles:** these are not checked. Results are unspecified, but the FSM still completes and returns to IDLE.
- `rom_addr` is 0 in IDLE and DONE.
- `in_valid` is ignored while `busy`=1, with no queueing. This means an upstream holding `in_valid` high gets exactly one accept per transaction.
- A new angle cannot be accepted in the same cycle that the result is released. The earliest possible accept is the cycle after the DONE→IDLE edge.
- **Reset mid-operation:** any state returns asynchronously to IDLE, with all outputs at their reset values. The partial result is discarded.

## Timing

- Accept occurs at edge E0, when `in_valid` and `in_ready` are both high.
- RUN edges are E1..E16, with `rom_addr`=0..15 during the cycles that precede those edges respectively.
- `out_valid` rises after E16. Latency is 16 cycles from accept to valid.
- Minimum throughput is one result per 18 cycles: accept, 16 RUN cycles, one DONE cycle with `out_ready`=1, then IDLE.
- `out_valid` stays high, and `cos_out`/`sin_out` stay stable, for as long as `out_ready`=0.
- `in_ready`, `out_valid`, `busy` and `rom_addr` are decoded directly from registered state and `iter`. There is no combinational path from `in_valid` or `out_ready` to any output.
- `rom_data` is sampled in the same cycle that `rom_addr` is driven. The ROM is purely combinational.

## Test plan

- **Zero angle:** `angle`=0 with `out_ready`=1. Expect `out_valid` exactly 16 edges after accept, `cos_out`=32768±16 and `sin_out`=0±16. The ROM address trace must read 0,1,…,15.
- **±π/4:** `angle`=20'h06487 gives cos=23170±16 and sin=23170±16. `angle`=−20'h06487 (20'hF9B79) gives cos=23170±16 and sin=−23170±16.
- **π/2:** `angle`=20'h0C90F gives cos=0±16 and sin=32768±16. `angle`=−20'h0C90F gives sin=−32768±16.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` rises, with `in_valid` held high throughout.
  - Outputs must stay constant and `in_ready` must stay 0.
  - Exactly one new accept must occur, on the cycle after the release edge.
- **Reset mid-RUN:** assert `reset` while `rom_addr`=7.
  - All outputs go immediately to reset values: `in_ready`=1, `busy`=0 and `cos_out`/`sin_out`=0.
  - A following transaction with `angle`=0 completes normally.
- **Back-to-back sweep:** apply 64 random angles within ±20'h0C90F, with `in_valid` and `out_ready` randomly toggled. Every result must match the model within ±16 LSB, and results must arrive in input order.
